// File: rtl/adder_sched_pkg.sv
// Shared definitions for the adder scheduler: FSM state encoding, default datapath
// width, requester-ID width and the settle-counter width.
package adder_sched_pkg;

  localparam int unsigned WIDTH_DEFAULT = 40;
  localparam int unsigned ID_WIDTH      = 1;
  // Wide enough for SETTLE-1 with SETTLE in 1..15.
  localparam int unsigned CNT_WIDTH     = 4;

  localparam logic [1:0] IdleEnc   = 2'd0;
  localparam logic [1:0] SettleEnc = 2'd1;
  localparam logic [1:0] RespEnc   = 2'd2;

  typedef enum logic [1:0] {
    StIdle   = IdleEnc,
    StSettle = SettleEnc,
    StResp   = RespEnc
  } state_e;

  typedef logic [ID_WIDTH-1:0] id_t;

endpackage

// File: rtl/ripple_adder.sv
// Purely combinational ripple-carry adder.
// Ports:
//   a, b  : WIDTH-bit unsigned operands
//   cin   : carry in
//   sum   : WIDTH-bit sum
//   cout  : carry out of the top bit
// The scheduler samples this adder as a multicycle path, so the full carry chain is
// allowed SETTLE clock periods to resolve.
module ripple_adder #(
  parameter int unsigned WIDTH = 40
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Carry is threaded through a block-local variable to keep the chain a single
  // combinational process.
  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/adder_scheduler.sv
// Shares one ripple-carry adder between two valid/ready requesters. A granted request
// loads the operand registers, waits SETTLE clocks for the adder to resolve, then
// presents a registered, ID-tagged result until the consumer accepts it.
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   reqN_valid / reqN_ready    : requester N handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_cin   : requester N operands
//   rsp_valid / rsp_ready      : result handshake
//   rsp_sum, rsp_cout, rsp_id  : registered result and originating requester
// Timing constraint: operand registers -> rsp_sum/rsp_cout is a SETTLE-cycle
// multicycle path.
module adder_scheduler
  import adder_sched_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEFAULT,
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id
);

  localparam logic [CNT_WIDTH-1:0] CntLoad = CNT_WIDTH'(SETTLE - 1);

  state_e                 state_q, state_d;
  logic                   last_q, last_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]       op_a_q, op_a_d;
  logic [WIDTH-1:0]       op_b_q, op_b_d;
  logic                   op_cin_q, op_cin_d;
  id_t                    op_id_q, op_id_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]       rsp_sum_q, rsp_sum_d;
  logic                   rsp_cout_q, rsp_cout_d;
  id_t                    rsp_id_q, rsp_id_d;

  logic                   any_valid;
  logic                   grant;
  logic                   handshake;
  logic [WIDTH-1:0]       add_sum;
  logic                   add_cout;

  // Adder sees only the operand registers, which stay frozen outside IDLE.
  ripple_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (op_a_q),
    .b    (op_b_q),
    .cin  (op_cin_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Round-robin: on a tie the requester not granted last wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_q;
    end else begin
      grant = req1_valid;
    end
    // rst gating keeps readys low during reset even though state is already IDLE.
    req0_ready = !rst && (state_q == StIdle) && any_valid && !grant;
    req1_ready = !rst && (state_q == StIdle) && any_valid && grant;
    handshake  = req0_ready | req1_ready;
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_cin_d    = op_cin_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_id_d    = rsp_id_q;

    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          op_a_d   = grant ? req1_a   : req0_a;
          op_b_d   = grant ? req1_b   : req0_b;
          op_cin_d = grant ? req1_cin : req0_cin;
          op_id_d  = id_t'(grant);
          last_d   = grant;
          cnt_d    = CntLoad;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end else begin
          rsp_sum_d   = add_sum;
          rsp_cout_d  = add_cout;
          rsp_id_d    = op_id_q;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_cin_q    <= 1'b0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_cin_q    <= op_cin_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_scheduler.sv
// Bench for adder_scheduler: a SETTLE=2 instance checked through a response scoreboard
// and handshake/latency monitors, plus a SETTLE=1 instance checked directly.
module tb_adder_scheduler;

  localparam int W = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic          req0_valid, req0_ready, req0_cin;
  logic [W-1:0]  req0_a, req0_b;
  logic          req1_valid, req1_ready, req1_cin;
  logic [W-1:0]  req1_a, req1_b;
  logic          rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [W-1:0]  rsp_sum;

  logic          s1_req0_valid, s1_req0_ready, s1_req0_cin;
  logic [W-1:0]  s1_req0_a, s1_req0_b;
  logic          s1_req1_valid, s1_req1_ready, s1_req1_cin;
  logic [W-1:0]  s1_req1_a, s1_req1_b;
  logic          s1_rsp_valid, s1_rsp_ready, s1_rsp_cout, s1_rsp_id;
  logic [W-1:0]  s1_rsp_sum;

  adder_scheduler #(.WIDTH(W), .SETTLE(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id)
  );

  adder_scheduler #(.WIDTH(W), .SETTLE(1)) dut_s1 (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (s1_req0_valid),
    .req0_ready (s1_req0_ready),
    .req0_a     (s1_req0_a),
    .req0_b     (s1_req0_b),
    .req0_cin   (s1_req0_cin),
    .req1_valid (s1_req1_valid),
    .req1_ready (s1_req1_ready),
    .req1_a     (s1_req1_a),
    .req1_b     (s1_req1_b),
    .req1_cin   (s1_req1_cin),
    .rsp_valid  (s1_rsp_valid),
    .rsp_ready  (s1_rsp_ready),
    .rsp_sum    (s1_rsp_sum),
    .rsp_cout   (s1_rsp_cout),
    .rsp_id     (s1_rsp_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  exp_t exp_q[$];
  int   hs_q[$];
  bit   tie_phase = 1'b0;
  int   last_hs   = -1;
  logic prev_v    = 1'b0;

  // Tie-phase operand tables and hand-computed results.
  logic [W-1:0] t0_a[3] = '{40'd1, 40'd100, 40'hFF_FFFF_FFFF};
  logic [W-1:0] t0_b[3] = '{40'd2, 40'd200, 40'd1};
  logic         t0_c[3] = '{1'b0, 1'b1, 1'b0};
  logic [W-1:0] t0_s[3] = '{40'd3, 40'd301, 40'd0};
  logic         t0_o[3] = '{1'b0, 1'b0, 1'b1};
  logic [W-1:0] t1_a[3] = '{40'd10, 40'd7, 40'h80_0000_0000};
  logic [W-1:0] t1_b[3] = '{40'd20, 40'd8, 40'h80_0000_0000};
  logic         t1_c[3] = '{1'b0, 1'b1, 1'b0};
  logic [W-1:0] t1_s[3] = '{40'd30, 40'd16, 40'd0};
  logic         t1_o[3] = '{1'b0, 1'b0, 1'b1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not occur as expected", name);
  endtask

  task automatic push_exp(input logic id, input logic [W-1:0] sum, input logic cout);
    exp_t e;
    e.id   = id;
    e.sum  = sum;
    e.cout = cout;
    exp_q.push_back(e);
  endtask

  // Handshake/latency monitor for the SETTLE=2 instance.
  always @(negedge clk) begin
    if (!rst) begin
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        hs_q.push_back(cyc + 1);
        if (tie_phase) begin
          check("both_ready", 64'(req0_ready && req1_ready), 64'd0);
          if (last_hs >= 0) check("issue_interval", 64'(cyc + 1 - last_hs), 64'd4);
          last_hs <= cyc + 1;
        end
      end
      if (!tie_phase) last_hs <= -1;
    end
  end

  // Response scoreboard monitor.
  always @(negedge clk) begin
    if (rst) begin
      prev_v <= 1'b0;
    end else begin
      if (rsp_valid && !prev_v) begin
        if (hs_q.size() == 0) fail("latency_no_handshake");
        else check("latency", 64'(cyc - hs_q.pop_front()), 64'd2);
      end
      prev_v <= rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_rsp");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(e.id));
          check("rsp_sum", 64'(rsp_sum), 64'(e.sum));
          check("rsp_cout", 64'(rsp_cout), 64'(e.cout));
        end
      end
    end
  end

  task automatic drop_valid(input bit id);
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic wait_hs(input bit id);
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = id ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
    end
    if (!got) fail("handshake_timeout");
    @(posedge clk);
    #1;
    drop_valid(id);
  endtask

  task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic [W-1:0] esum, input logic ecout);
    push_exp(id, esum, ecout);
    if (id) begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
    end
    wait_hs(id);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    int i0, i1, hsc;
    bit h0, h1, got;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    rsp_ready  = 1'b1;
    s1_req0_valid = 1'b1; s1_req0_a = '0; s1_req0_b = '0; s1_req0_cin = 1'b0;
    s1_req1_valid = 1'b0; s1_req1_a = '0; s1_req1_b = '0; s1_req1_cin = 1'b0;
    s1_rsp_ready  = 1'b1;

    // Reset state, with valids asserted to show readys stay low.
    repeat (2) @(negedge clk);
    check("rst_req0_ready", 64'(req0_ready), 64'd0);
    check("rst_req1_ready", 64'(req1_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_sum", 64'(rsp_sum), 64'd0);
    check("rst_rsp_cout", 64'(rsp_cout), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_s1_ready", 64'(s1_req0_ready | s1_req1_ready), 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0; s1_req0_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Single op on req0.
    issue(1'b0, 40'd11, 40'd1111, 1'b0, 40'd1122, 1'b0);
    drain();

    // Overflow on req1.
    issue(1'b1, '1, '1, 1'b1, '1, 1'b1);
    issue(1'b1, '1, '1, 1'b0, 40'hFF_FFFF_FFFE, 1'b1);
    drain();

    // Both valid continuously: grants alternate starting with req0, 4-clock issue.
    for (int k = 0; k < 3; k++) begin
      push_exp(1'b0, t0_s[k], t0_o[k]);
      push_exp(1'b1, t1_s[k], t1_o[k]);
    end
    tie_phase = 1'b1;
    i0 = 0; i1 = 0;
    req0_a = t0_a[0]; req0_b = t0_b[0]; req0_cin = t0_c[0]; req0_valid = 1'b1;
    req1_a = t1_a[0]; req1_b = t1_b[0]; req1_cin = t1_c[0]; req1_valid = 1'b1;
    for (int c = 0; c < 200 && (i0 < 3 || i1 < 3); c++) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (h0) begin
        i0++;
        if (i0 < 3) begin
          req0_a = t0_a[i0]; req0_b = t0_b[i0]; req0_cin = t0_c[i0];
        end else req0_valid = 1'b0;
      end
      if (h1) begin
        i1++;
        if (i1 < 3) begin
          req1_a = t1_a[i1]; req1_b = t1_b[i1]; req1_cin = t1_c[i1];
        end else req1_valid = 1'b0;
      end
    end
    if (i0 < 3 || i1 < 3) fail("tie_phase_timeout");
    drain();
    tie_phase = 1'b0;

    // Backpressure: response held 5 cycles while req1 waits.
    rsp_ready = 1'b0;
    issue(1'b0, 40'h12_3456_789A, 40'h0F_0F0F_0F0F, 1'b1, 40'h21_4365_87AA, 1'b0);
    push_exp(1'b1, 40'd7, 1'b0);
    req1_a = 40'd3; req1_b = 40'd4; req1_cin = 1'b0; req1_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = rsp_valid;
    end
    if (!got) fail("bp_rsp_timeout");
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_sum", 64'(rsp_sum), 64'h21_4365_87AA);
      check("bp_id", 64'(rsp_id), 64'd0);
      check("bp_readys", 64'({req0_ready, req1_ready}), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("no_accept_in_resp", 64'(req1_ready), 64'd0);
    @(negedge clk);
    check("bp_rsp_drop", 64'(rsp_valid), 64'd0);
    check("bp_req1_ready", 64'(req1_ready), 64'd1);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    drain();

    // Reset one cycle into SETTLE discards the operation.
    req0_a = 40'd1; req0_b = 40'd1; req0_cin = 1'b0; req0_valid = 1'b1;
    wait_hs(1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst = 1'b1;
    hs_q.delete();
    #1;
    check("mid_rst_outputs", 64'({rsp_valid, rsp_cout, rsp_id, req0_ready, req1_ready}),
          64'd0);
    check("mid_rst_sum", 64'(rsp_sum), 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("no_stale_rsp", 64'(rsp_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    push_exp(1'b0, 40'd5, 1'b0);
    push_exp(1'b1, 40'd9, 1'b0);
    req0_a = 40'd2; req0_b = 40'd3; req0_cin = 1'b0; req0_valid = 1'b1;
    req1_a = 40'd4; req1_b = 40'd4; req1_cin = 1'b1; req1_valid = 1'b1;
    wait_hs(1'b0);
    wait_hs(1'b1);
    drain();

    // SETTLE=1 instance: result one clock after the handshake.
    s1_req0_a = 40'd5; s1_req0_b = 40'd7; s1_req0_cin = 1'b1; s1_req0_valid = 1'b1;
    got = 1'b0; hsc = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = s1_req0_ready;
      hsc = cyc + 1;
    end
    if (!got) fail("s1_handshake_timeout");
    @(posedge clk);
    #1 s1_req0_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = s1_rsp_valid;
    end
    if (!got) fail("s1_rsp_timeout");
    check("s1_latency", 64'(cyc - hsc), 64'd1);
    check("s1_sum", 64'(s1_rsp_sum), 64'd13);
    check("s1_cout_id", 64'({s1_rsp_cout, s1_rsp_id}), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_scheduler.md
# adder_scheduler

Arbitrates one shared 40-bit ripple-carry adder between two requesters and sequences each addition through a fixed settle window. The adder is treated as a multicycle path, so its result is captured only after `SETTLE` clocks. The block sits between two operand producers and a single result consumer. Each requester uses valid/ready; results return tagged with the requester ID.

## Interface
- `WIDTH`, 40, operand/sum width; must match the adder instance.
- `SETTLE`, 2, clocks the operands are held before the sum is sampled; legal range 1..15.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has operands.
- `req0_ready`  out  1  requester 0 operands accepted this cycle.
- `req0_a`, `req0_b`  in  WIDTH  requester 0 operands.
- `req0_cin`  in  1  requester 0 carry in.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cin`: same as requester 0, for requester 1.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_sum`  out  WIDTH  registered sum.
- `rsp_cout`  out  1  registered carry out.
- `rsp_id`  out  1  requester that issued the operation.

## Operation
- FSM states: IDLE, SETTLE, RESP. Reset state is IDLE.
- **IDLE**
  - Grant goes to a requester with valid high. If both are valid, the one not granted last wins (round-robin).
  - `reqN_ready` = (state==IDLE) && grant==N. It is combinational and one-hot or zero.
  - On handshake: latch a, b and cin into the operand registers that drive the adder, latch the ID, load `cnt`=SETTLE-1, and go to SETTLE.
- **SETTLE**
  - Operand registers are frozen.
  - If `cnt`≠0: decrement `cnt`.
  - If `cnt`==0: capture adder S/C_out into `rsp_sum`/`rsp_cout`, set `rsp_valid`, and go to RESP.
- **RESP**
  - `rsp_*` are held stable while `rsp_valid` && !`rsp_ready`.
  - On `rsp_ready`: clear `rsp_valid` and go to IDLE. No new request is accepted in the same cycle.
- Arithmetic is unsigned: {`rsp_cout`,`rsp_sum`} = a + b + cin, WIDTH+1 bits, with no truncation beyond that.
- The last-grant pointer updates only on an accepted handshake. Its reset value is 1, so requester 0 wins the first tie.
- A requester must hold its operands stable while valid && !ready. A valid that drops before ready is a legal withdrawal.

## Timing
- Reset values:
  - `req0_ready`=`req1_ready`=0 while rst is high.
  - `rsp_valid`=0, `rsp_sum`=0, `rsp_cout`=0, `rsp_id`=0.
  - Operand registers = 0, `cnt`=0, last-grant=1.
- Latency: handshake at edge E0 → `rsp_valid` high after edge E0+SETTLE. With SETTLE=2, that is 2 clocks.
- Minimum issue interval is SETTLE+2 clocks: SETTLE cycles, one RESP cycle with `rsp_ready` high, and one IDLE cycle.
- Simultaneous valids: exactly one ready is asserted. The loser keeps valid and is served next.
- `rsp_ready` held high entering RESP: the response lasts exactly one cycle.
- Reset mid-operation (SETTLE or RESP): the operation is discarded, all outputs go to their reset values immediately, and no response is produced after reset.
- The adder input-to-output path must meet SETTLE×clock period; this is declared as a multicycle constraint.

## Structure
- Package `adder_sched_pkg`:
  - state encoding localparams (IDLE=2'd0, SETTLE=2'd1, RESP=2'd2);
  - `WIDTH_DEFAULT`=40;
  - the ID width.
- Sub-module: one `ripple_adder` instance. It is driven only from the operand registers and has no logic in its input path.
- The arbiter, counter and FSM are inline, since the arbiter is too small to justify a separate module.

## Test plan
- Single op on req0: A=11, B=1111, cin=0 → `rsp_valid` 2 clocks after the handshake; `rsp_sum`=1122, `rsp_cout`=0, `rsp_id`=0.
- Overflow on req1: A=B=all ones, cin=1 → `rsp_sum`=all ones, `rsp_cout`=1, `rsp_id`=1. The same operands with cin=0 → `rsp_sum`=0xFF_FFFF_FFFE, `rsp_cout`=1.
- Both valid every cycle, with `rsp_ready` tied high, for 6 ops → grants alternate 0,1,0,1,0,1, the first goes to req0, and the ops are issued every 4 clocks.
- Backpressure: hold `rsp_ready` low for 5 cycles in RESP → `rsp_*` stay stable and both readys stay 0. Release → `rsp_valid` drops the next edge.
- Reset asserted one cycle into SETTLE → all outputs go to 0 immediately. After deassert, no stale response appears, and the next tie grants req0.
- SETTLE=1 build: A=5, B=7, cin=1 → `rsp_sum`=13, and `rsp_valid` rises 1 clock after the handshake.
